// File: rtl/inst_mem_responder.sv
// Instruction memory responder: fixed-latency fetch pipeline feeding a 4-entry
// response FIFO, with credit-based request flow control, flush and program load.
module inst_mem_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_error,
  input  logic        load_en,
  input  logic [9:0]  load_addr,
  input  logic [31:0] load_data
);

  localparam logic [33:0] ADDR_LIMIT = 34'(DEPTH_WORDS) * 34'd4;
  localparam logic [10:0] LOAD_LIMIT = 11'(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [LATENCY-1:0] pipe_valid;
  logic [31:0]        pipe_addr  [LATENCY];
  logic [31:0]        pipe_instr [LATENCY];
  logic               pipe_err   [LATENCY];

  logic [31:0] fifo_addr  [4];
  logic [31:0] fifo_instr [4];
  logic        fifo_err   [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  fifo_count;
  logic [2:0]  in_flight;

  logic accept;
  logic req_err;
  logic push;
  logic pop;

  assign req_err = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr} >= ADDR_LIMIT);

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LATENCY; i++)
      in_flight = in_flight + 3'(pipe_valid[i]);
  end

  // Credits come only from registered state, so a pop frees a slot next cycle.
  assign req_ready = !rst && !flush && (({1'b0, in_flight} + {1'b0, fifo_count}) < 4'd4);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fifo_count != 3'd0);
  assign push      = pipe_valid[LATENCY-1] && !flush;
  assign pop       = rsp_valid && rsp_ready && !flush;

  assign rsp_instr = rsp_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign rsp_addr  = rsp_valid ? fifo_addr[rd_ptr]  : 32'h0;
  assign rsp_error = rsp_valid ? fifo_err[rd_ptr]   : 1'b0;

  always_ff @(posedge clk) begin
    if (load_en && ({1'b0, load_addr} < LOAD_LIMIT))
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
    end else if (flush) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++)
        pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // The read happens at the accept edge, so a same-edge load is not yet visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_addr[0] <= req_addr;
      pipe_err[0]  <= req_err;
      if (req_err)
        pipe_instr[0] <= 32'h0;
      else
        pipe_instr[0] <= mem[req_addr[11:2]];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_addr[i]  <= pipe_addr[i-1];
      pipe_err[i]   <= pipe_err[i-1];
      pipe_instr[i] <= pipe_instr[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= pipe_addr[LATENCY-1];
      fifo_instr[wr_ptr] <= pipe_instr[LATENCY-1];
      fifo_err[wr_ptr]   <= pipe_err[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench for inst_mem_responder: accepted requests push an expected
// response, response handshakes pop and compare in acceptance order.
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_error;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  always #5 clk = ~clk;

  inst_mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_error (rsp_error),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } rsp_t;

  rsp_t        sb_q[$];
  logic [31:0] model_mem [1024];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          popped;
  bit          unexp;
  rsp_t        seen;
  rsp_t        want;

  function automatic rsp_t expect_rsp(input logic [31:0] a);
    rsp_t r;
    r.addr  = a;
    r.err   = (a[1:0] != 2'b00) || (a >= 32'd4096);
    r.instr = r.err ? 32'h0 : model_mem[a[11:2]];
    return r;
  endfunction

  // One clock cycle: record handshakes at the negedge, then advance past the posedge.
  task automatic step();
    @(negedge clk);
    popped = 1'b0;
    unexp  = 1'b0;
    seen   = '0;
    want   = '0;
    if (rsp_valid && rsp_ready) begin
      popped = 1'b1;
      seen   = {rsp_addr, rsp_instr, rsp_error};
      if (sb_q.size() == 0)
        unexp = 1'b1;
      else
        want = sb_q.pop_front();
    end
    if (flush)
      sb_q.delete();
    if (req_valid && req_ready)
      sb_q.push_back(expect_rsp(req_addr));
    if (load_en)
      model_mem[load_addr] = load_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_error, rsp_instr, rsp_addr} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b err=%b instr=%h addr=%h, want all zero",
               req_ready, rsp_valid, rsp_error, rsp_instr, rsp_addr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_load_program();
    for (int i = 0; i < 8; i++) begin
      load_en   = 1'b1;
      load_addr = 10'(i);
      load_data = (i == 0) ? 32'hE3A01005 : (i == 1) ? 32'hE2811001 : 32'h1000_0000 + 32'(i);
      step();
    end
    load_en = 1'b0;
  endtask

  task automatic test_basic();
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 2);
      req_addr  = (c == 1) ? 32'h4 : 32'h0;
      step();
      if (popped) begin
        n_checks++;
        if (unexp || seen !== want) begin
          n_fail++;
          $display("[TB] FAIL basic_rsp: got=%h want=%h q_empty=%0b", seen, want, unexp);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (rsp_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL basic_early: rsp_valid got %b want 0 one cycle after accept", rsp_valid);
        end
      end
      if (c == 2) begin
        n_checks++;
        if ({rsp_valid, rsp_instr, rsp_addr} !== {1'b1, 32'hE3A01005, 32'h0}) begin
          n_fail++;
          $display("[TB] FAIL basic_first: got vld=%b instr=%h addr=%h want 1 e3a01005 0",
                   rsp_valid, rsp_instr, rsp_addr);
        end
      end
      if (c == 3) begin
        n_checks++;
        if ({rsp_valid, rsp_instr, rsp_addr} !== {1'b1, 32'hE2811001, 32'h4}) begin
          n_fail++;
          $display("[TB] FAIL basic_second: got vld=%b instr=%h addr=%h want 1 e2811001 4",
                   rsp_valid, rsp_instr, rsp_addr);
        end
      end
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL basic_drain: rsp_valid=%b pending=%0d want 0 0", rsp_valid, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    rsp_t hold;
    int   pops = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'(c * 4);
      step();
      if (popped) begin
        pops++;
        n_checks++;
        if (unexp || seen !== want) begin
          n_fail++;
          $display("[TB] FAIL bp_fill_rsp: got=%h want=%h q_empty=%0b", seen, want, unexp);
        end
      end
    end
    req_addr = 32'h10;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_full: req_ready got %b want 0 with four outstanding", req_ready);
    end
    hold = {rsp_addr, rsp_instr, rsp_error};
    n_checks++;
    if (rsp_valid !== 1'b1 || hold !== {32'h0, 32'hE3A01005, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL bp_head: got vld=%b head=%h want 1 %h", rsp_valid, hold,
               {32'h0, 32'hE3A01005, 1'b0});
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (popped) begin
        pops++;
        n_checks++;
        if (unexp || seen !== want) begin
          n_fail++;
          $display("[TB] FAIL bp_hold_rsp: got=%h want=%h q_empty=%0b", seen, want, unexp);
        end
      end
      n_checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || {rsp_addr, rsp_instr, rsp_error} !== hold) begin
        n_fail++;
        $display("[TB] FAIL bp_stable: rdy=%b vld=%b head=%h want 0 1 %h", req_ready, rsp_valid,
                 {rsp_addr, rsp_instr, rsp_error}, hold);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_no_forward: req_ready got %b want 0 before the pop edge", req_ready);
    end
    step();
    if (popped) begin
      pops++;
      n_checks++;
      if (unexp || seen !== want) begin
        n_fail++;
        $display("[TB] FAIL bp_first_pop: got=%h want=%h q_empty=%0b", seen, want, unexp);
      end
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_credit: req_ready got %b want 1 the cycle after the pop", req_ready);
    end
    for (int c = 0; c < 12; c++) begin
      step();
      req_valid = 1'b0;
      if (popped) begin
        pops++;
        n_checks++;
        if (unexp || seen !== want) begin
          n_fail++;
          $display("[TB] FAIL bp_drain_rsp: got=%h want=%h q_empty=%0b", seen, want, unexp);
        end
      end
    end
    n_checks++;
    if (pops != 5 || sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL bp_count: got %0d responses, %0d pending, want 5 and 0", pops, sb_q.size());
    end
  endtask

  task automatic test_errors();
    logic [31:0] err_addrs [3] = '{32'h2, 32'h1000, 32'h3FFC};
    int          pops = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 3);
      req_addr  = err_addrs[(c < 3) ? c : 0];
      step();
      if (popped) begin
        pops++;
        n_checks++;
        if (unexp || seen !== want || seen.err !== 1'b1 || seen.instr !== 32'h0) begin
          n_fail++;
          $display("[TB] FAIL error_rsp: got=%h want=%h (err=1 instr=0) q_empty=%0b", seen, want, unexp);
        end
      end
    end
    n_checks++;
    if (pops != 3 || sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL error_count: got %0d responses, %0d pending, want 3 and 0", pops, sb_q.size());
    end
  endtask

  task automatic test_flush();
    int pops = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'(c * 4);
      step();
    end
    flush     = 1'b1;
    req_addr  = 32'hC;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_ready: req_ready got %b want 0 during flush", req_ready);
    end
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_valid: rsp_valid got %b want 0 after flush", rsp_valid);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c == 5);
      req_addr  = 32'h8;
      step();
      if (popped) begin
        pops++;
        n_checks++;
        if (unexp || seen !== want || seen.instr !== 32'h1000_0002) begin
          n_fail++;
          $display("[TB] FAIL flush_rsp: got=%h want=%h q_empty=%0b", seen, want, unexp);
        end
      end
    end
    n_checks++;
    if (pops != 1 || sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL flush_count: got %0d responses, %0d pending, want 1 and 0", pops, sb_q.size());
    end
  endtask

  task automatic test_load_collision();
    int pops = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c == 0) || (c == 6);
      req_addr  = 32'h4;
      load_en   = (c == 0);
      load_addr = 10'd1;
      load_data = 32'hDEADBEEF;
      step();
      if (popped) begin
        pops++;
        n_checks++;
        if (unexp || seen !== want ||
            seen.instr !== ((pops == 1) ? 32'hE2811001 : 32'hDEADBEEF)) begin
          n_fail++;
          $display("[TB] FAIL collision_rsp: got=%h want=%h q_empty=%0b", seen, want, unexp);
        end
      end
    end
    load_en = 1'b0;
    n_checks++;
    if (pops != 2 || sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL collision_count: got %0d responses, %0d pending, want 2 and 0", pops, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int pops = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = (c < 2);
      req_addr  = (c == 1) ? 32'h4 : 32'h0;
      step();
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_pre: rsp_valid got %b want 1 with responses queued", rsp_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_error, rsp_instr, rsp_addr} !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid: got rdy=%b vld=%b err=%b instr=%h addr=%h, want all zero",
               req_ready, rsp_valid, rsp_error, rsp_instr, rsp_addr);
    end
    sb_q.delete();
    step();
    step();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      req_valid = (c == 6) || (c == 7);
      req_addr  = (c == 7) ? 32'h4 : 32'h0;
      step();
      if (popped) begin
        pops++;
        n_checks++;
        if (unexp || seen !== want ||
            seen.instr !== ((pops == 1) ? 32'hE3A01005 : 32'hDEADBEEF)) begin
          n_fail++;
          $display("[TB] FAIL rst_after_rsp: got=%h want=%h q_empty=%0b", seen, want, unexp);
        end
      end
    end
    n_checks++;
    if (pops != 2 || sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rst_after_count: got %0d responses, %0d pending, want 2 and 0", pops, sb_q.size());
    end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    load_en   = 1'b0;
    load_addr = 10'd0;
    load_data = 32'h0;
    #1 rst = 1'b1;
    test_reset();
    test_load_program();
    test_basic();
    test_backpressure();
    test_errors();
    test_flush();
    test_load_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the test sequence ended");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
